load_seq_ctrl: RTL and testbench

- Sequencer for all memory loads: LB, LBU, LH, LHU, LW, LWL and LWR.
- Issues a single word-aligned read on the data bus with wait-state handshake, then aligns and extends the returned word.
- For LWL/LWR it drives the partial-word merge block (lr_en, lrmux, masked_data, bout) and registers that block's final_data as the result.
- Sits between the CPU execute stage and the data-memory bus.

---
 rtl/load_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_load_seq_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/load_seq_ctrl.sv
// load_seq_ctrl: sequencer for every memory load (LB/LBU/LH/LHU/LW/LWL/LWR).
//   - Validates the request, issues one word-aligned bus read (with
//     wait-state stall), aligns/extends the returned word and, for LWL/LWR,
//     drives the external partial-word merge block and captures its output.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start/op/addr/rt_old  load request from execute (sampled in IDLE only)
//   mem_*             data bus master (read, byteenable, waitrequest, readdata)
//   lr_en/lrmux/masked_data/bout -> merge block, final_data <- merge block
//   busy, done, err, result      status/result to the CPU
// Every output is a flop: the comb process computes the next value of each
// output alongside the next state, and one always_ff registers them.
module load_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt_old,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        lr_en,
  output logic [2:0]  lrmux,
  output logic [31:0] masked_data,
  output logic [31:0] bout,
  input  logic [31:0] final_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);

  localparam logic [2:0] OP_LB  = 3'b000, OP_LBU = 3'b001, OP_LH  = 3'b010,
                         OP_LHU = 3'b011, OP_LW  = 3'b100, OP_LWL = 3'b101,
                         OP_LWR = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, MERGE, DONE} state_t;

  state_t      state_q, state_n;
  logic [2:0]  op_q, op_n;
  logic [1:0]  k_q, k_n;
  logic [31:0] mem_address_n, masked_n, bout_n, result_n;
  logic [3:0]  be_n;
  logic [2:0]  lrmux_n;
  logic        mem_read_n, lr_en_n, busy_n, done_n, err_n;

  function automatic logic [3:0] lane_mask(input logic [2:0] o, input logic [1:0] k);
    case (o)
      OP_LB, OP_LBU: lane_mask = 4'b0001 << k;
      OP_LH, OP_LHU: lane_mask = k[1] ? 4'b1100 : 4'b0011;
      OP_LW:         lane_mask = 4'b1111;
      OP_LWL:        lane_mask = 4'b1111 >> (~k);  // lanes 0..k
      OP_LWR:        lane_mask = 4'b1111 << k;     // lanes k..3
      default:       lane_mask = 4'b0000;
    endcase
  endfunction

  // Little-endian lane extraction; LWL shifts by 3-k (== ~k on 2 bits).
  function automatic logic [31:0] align(input logic [2:0] o, input logic [1:0] k,
                                        input logic [31:0] d);
    logic [4:0]  sh_k, sh_nk;
    logic [7:0]  b;
    logic [15:0] h;
    sh_k  = {k, 3'b000};
    sh_nk = {~k, 3'b000};
    b     = d[sh_k +: 8];
    h     = k[1] ? d[31:16] : d[15:0];
    case (o)
      OP_LB:   align = {{24{b[7]}}, b};
      OP_LBU:  align = {24'h0, b};
      OP_LH:   align = {{16{h[15]}}, h};
      OP_LHU:  align = {16'h0, h};
      OP_LW:   align = d;
      OP_LWL:  align = d << sh_nk;
      OP_LWR:  align = d >> sh_k;
      default: align = 32'h0;
    endcase
  endfunction

  logic req_bad;
  assign req_bad = (op == 3'b111) ||
                   (((op == OP_LH) || (op == OP_LHU)) && addr[0]) ||
                   ((op == OP_LW) && (addr[1:0] != 2'b00));

  always_comb begin
    state_n       = state_q;
    op_n          = op_q;
    k_n           = k_q;
    mem_address_n = mem_address;
    mem_read_n    = mem_read;
    be_n          = mem_byteenable;
    lr_en_n       = 1'b0;
    lrmux_n       = lrmux;
    masked_n      = masked_data;
    bout_n        = bout;
    done_n        = 1'b0;
    err_n         = err;
    result_n      = result;
    case (state_q)
      IDLE: if (start) begin
        op_n          = op;
        k_n           = addr[1:0];
        bout_n        = rt_old;
        mem_address_n = {addr[31:2], 2'b00};
        if (req_bad) begin
          // Rejected up front: no bus cycle, report straight away.
          state_n  = DONE;
          done_n   = 1'b1;
          err_n    = 1'b1;
          result_n = 32'h0;
        end else begin
          state_n    = REQ;
          mem_read_n = 1'b1;
          be_n       = lane_mask(op, addr[1:0]);
        end
      end
      REQ: if (!mem_waitrequest) begin
        // Readdata is only valid in the acceptance cycle, so the aligned
        // word is captured now into the merge-block drive registers.
        state_n    = MERGE;
        mem_read_n = 1'b0;
        be_n       = 4'b0000;
        lr_en_n    = (op_q == OP_LWL) || (op_q == OP_LWR);
        lrmux_n    = {op_q == OP_LWR, k_q};
        masked_n   = align(op_q, k_q, mem_readdata);
      end
      MERGE: begin
        state_n  = DONE;
        done_n   = 1'b1;
        err_n    = 1'b0;
        result_n = lr_en ? final_data : masked_data;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= 3'b000;
      k_q            <= 2'b00;
      mem_address    <= 32'h0;
      mem_read       <= 1'b0;
      mem_byteenable <= 4'b0000;
      lr_en          <= 1'b0;
      lrmux          <= 3'b000;
      masked_data    <= 32'h0;
      bout           <= 32'h0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      result         <= 32'h0;
    end else begin
      state_q        <= state_n;
      op_q           <= op_n;
      k_q            <= k_n;
      mem_address    <= mem_address_n;
      mem_read       <= mem_read_n;
      mem_byteenable <= be_n;
      lr_en          <= lr_en_n;
      lrmux          <= lrmux_n;
      masked_data    <= masked_n;
      bout           <= bout_n;
      busy           <= busy_n;
      done           <= done_n;
      err            <= err_n;
      result         <= result_n;
    end
  end

endmodule

// File: tb/tb_load_seq_ctrl.sv
module tb_load_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] addr = 32'h0, rt_old = 32'h0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = 32'h0;
  logic        lr_en;
  logic [2:0]  lrmux;
  logic [31:0] masked_data, bout;
  logic [31:0] final_data;
  logic        busy, done, err;
  logic [31:0] result;

  int checks = 0, errors = 0;
  int wait_cfg = 0;
  int rd_cnt = 0, rd_total = 0, done_cnt = 0;

  typedef struct packed { logic e; logic [31:0] r; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  load_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .rt_old(rt_old),
    .mem_address(mem_address), .mem_read(mem_read), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .lr_en(lr_en), .lrmux(lrmux), .masked_data(masked_data), .bout(bout),
    .final_data(final_data), .busy(busy), .done(done), .err(err), .result(result)
  );

  // Merge block model: masked bytes overwrite, the rest come from rt (bout).
  logic [31:0] keep;
  always_comb begin
    case (lrmux)
      3'b000: keep = 32'h00FFFFFF;
      3'b001: keep = 32'h0000FFFF;
      3'b010: keep = 32'h000000FF;
      3'b101: keep = 32'hFF000000;
      3'b110: keep = 32'hFFFF0000;
      3'b111: keep = 32'hFFFFFF00;
      default: keep = 32'h0;
    endcase
    final_data = lr_en ? (masked_data | (bout & keep)) : masked_data;
  end

  // Bus slave: stall the first wait_cfg cycles of each read; monitor counters.
  always @(negedge clk) begin
    if (mem_read) begin
      mem_waitrequest = (rd_cnt < wait_cfg);
      rd_cnt++;
      rd_total++;
    end else begin
      mem_waitrequest = 1'b0;
      rd_cnt = 0;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load: exp_lat is the negedge count from the start edge to done.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] rt, input logic [31:0] rd, input int waits,
                     input logic [3:0] exp_be, input int exp_lat,
                     input logic [31:0] exp_res, input logic exp_err,
                     output logic [2:0] lrm, output logic [31:0] msk);
    int n, rd0;
    exp_t e;
    sb.push_back('{e: exp_err, r: exp_res});
    wait_cfg = waits;
    @(negedge clk);
    rd0 = rd_total;
    start = 1'b1; op = o; addr = a; rt_old = rt; mem_readdata = rd;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({tag, "_rd"}, {31'h0, mem_read}, {31'h0, exp_lat > 1});
    if (exp_lat > 1) begin
      chk({tag, "_addr"}, mem_address, {a[31:2], 2'b00});
      chk({tag, "_be"}, {28'h0, mem_byteenable}, {28'h0, exp_be});
    end
    lrm = 3'b000; msk = 32'h0;
    while (!done && n < 60) begin
      if (lr_en) begin lrm = lrmux; msk = masked_data; end
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    e = sb.pop_front();
    chk({tag, "_res"}, result, e.r);
    chk({tag, "_err"}, {31'h0, err}, {31'h0, e.e});
    chk({tag, "_rdcyc"}, rd_total - rd0, (exp_lat > 1) ? waits + 1 : 0);
  endtask

  initial begin
    logic [2:0]  lrm;
    logic [31:0] msk;
    int d0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd", {31'h0, mem_read}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_res", result, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_be", {28'h0, mem_byteenable}, 32'h0);
    reset = 1'b0;

    run("lw", 3'b100, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 3, 32'hDEADBEEF, 1'b0, lrm, msk);
    run("lb", 3'b000, 32'h103, 32'h0, 32'h80112233, 2, 4'b1000, 5, 32'hFFFFFF80, 1'b0, lrm, msk);
    run("lbu", 3'b001, 32'h103, 32'h0, 32'h80112233, 2, 4'b1000, 5, 32'h00000080, 1'b0, lrm, msk);
    run("lhu", 3'b011, 32'h102, 32'h0, 32'h80112233, 0, 4'b1100, 3, 32'h00008011, 1'b0, lrm, msk);
    run("lh", 3'b010, 32'h100, 32'h0, 32'h0000F00D, 1, 4'b0011, 4, 32'hFFFFF00D, 1'b0, lrm, msk);
    run("lwl", 3'b101, 32'h201, 32'h11223344, 32'hAABBCCDD, 0, 4'b0011, 3, 32'hCCDD3344, 1'b0, lrm, msk);
    chk("lwl_lrmux", {29'h0, lrm}, 32'h1);
    chk("lwl_mask", msk, 32'hCCDD0000);
    run("lwr", 3'b110, 32'h202, 32'h11223344, 32'hAABBCCDD, 0, 4'b1100, 3, 32'h1122AABB, 1'b0, lrm, msk);
    chk("lwr_lrmux", {29'h0, lrm}, 32'h6);
    chk("lwr_mask", msk, 32'h0000AABB);
    run("lwl3", 3'b101, 32'h203, 32'h11223344, 32'hAABBCCDD, 0, 4'b1111, 3, 32'hAABBCCDD, 1'b0, lrm, msk);
    run("lwr0", 3'b110, 32'h200, 32'h11223344, 32'hAABBCCDD, 0, 4'b1111, 3, 32'hAABBCCDD, 1'b0, lrm, msk);
    run("lh_mis", 3'b010, 32'h301, 32'h0, 32'h12345678, 0, 4'b0000, 1, 32'h0, 1'b1, lrm, msk);
    run("op7", 3'b111, 32'h300, 32'h0, 32'h12345678, 0, 4'b0000, 1, 32'h0, 1'b1, lrm, msk);
    run("lw_mis", 3'b100, 32'h302, 32'h0, 32'h12345678, 0, 4'b0000, 1, 32'h0, 1'b1, lrm, msk);

    // Reset during a stalled REQ aborts without a done pulse.
    wait_cfg = 1000;
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; op = 3'b100; addr = 32'h400;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_rd_pre", {31'h0, mem_read}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rd", {31'h0, mem_read}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    repeat (6) @(negedge clk);
    chk("abort_nodone", done_cnt - d0, 0);

    // start while busy is dropped: one done only, result of the first load.
    wait_cfg = 3;
    sb.push_back('{e: 1'b0, r: 32'hCAFEF00D});
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 3'b100; addr = 32'h500; mem_readdata = 32'hCAFEF00D;
    @(negedge clk);
    op = 3'b000; addr = 32'h501;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_once", done_cnt - d0, 1);
    begin
      exp_t e;
      e = sb.pop_front();
      chk("busy_res", result, e.r);
    end
    chk("busy_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
